// File: rtl/dt_pkg.sv
`timescale 1ns/1ps
// dt_pkg: shared constants and types for the distance-transform statistics stage.
//   IMG_W/IMG_H   : image geometry (128x128)
//   ADDR_W/DATA_W : result RAM address / data widths
//   CNT_W/SUM_W   : pixel-count and distance-sum widths (sized so they never overflow)
//   LAST_PIX      : raster address of the final pixel
//   stat_state_e  : statistics FSM state encoding
package dt_pkg;

  localparam int IMG_W  = 128;
  localparam int IMG_H  = 128;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 15;
  localparam int SUM_W  = 22;

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(IMG_W * IMG_H - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } stat_state_e;

endpackage

// File: rtl/dt_stat_acc.sv
`timescale 1ns/1ps
// dt_stat_acc: per-pixel accumulator for the statistics sweep.
//   clk, reset      : clock, asynchronous active-low reset
//   clr             : synchronous clear of all results (takes priority over en)
//   en              : accumulate pixel d located at addr
//   d, thr, addr    : pixel value, latched threshold, pixel raster address
//   max_val/max_addr: largest value and its earliest address
//   obj_cnt         : count of nonzero pixels
//   dist_sum        : sum of all pixel values
//   thr_cnt         : count of pixels with value >= thr
module dt_stat_acc
  import dt_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  input  logic [DATA_W-1:0] thr,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] max_val,
  output logic [ADDR_W-1:0] max_addr,
  output logic [CNT_W-1:0]  obj_cnt,
  output logic [SUM_W-1:0]  dist_sum,
  output logic [CNT_W-1:0]  thr_cnt
);

  logic [DATA_W-1:0] max_val_d,  max_val_q;
  logic [ADDR_W-1:0] max_addr_d, max_addr_q;
  logic [CNT_W-1:0]  obj_cnt_d,  obj_cnt_q;
  logic [SUM_W-1:0]  dist_sum_d, dist_sum_q;
  logic [CNT_W-1:0]  thr_cnt_d,  thr_cnt_q;

  // Next-state of the result registers: clear, accumulate one pixel, or hold.
  always_comb begin
    max_val_d  = max_val_q;
    max_addr_d = max_addr_q;
    obj_cnt_d  = obj_cnt_q;
    dist_sum_d = dist_sum_q;
    thr_cnt_d  = thr_cnt_q;
    if (clr) begin
      max_val_d  = {DATA_W{1'b0}};
      max_addr_d = {ADDR_W{1'b0}};
      obj_cnt_d  = {CNT_W{1'b0}};
      dist_sum_d = {SUM_W{1'b0}};
      thr_cnt_d  = {CNT_W{1'b0}};
    end else if (en) begin
      // Strict compare so ties keep the earliest raster address.
      if (d > max_val_q) begin
        max_val_d  = d;
        max_addr_d = addr;
      end else begin
        max_val_d  = max_val_q;
        max_addr_d = max_addr_q;
      end
      obj_cnt_d  = obj_cnt_q + ((d != {DATA_W{1'b0}}) ? CNT_W'(1'b1) : CNT_W'(1'b0));
      dist_sum_d = dist_sum_q + SUM_W'(d);
      thr_cnt_d  = thr_cnt_q + ((d >= thr) ? CNT_W'(1'b1) : CNT_W'(1'b0));
    end else begin
      max_val_d  = max_val_q;
      max_addr_d = max_addr_q;
    end
  end

  // Result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      max_val_q  <= {DATA_W{1'b0}};
      max_addr_q <= {ADDR_W{1'b0}};
      obj_cnt_q  <= {CNT_W{1'b0}};
      dist_sum_q <= {SUM_W{1'b0}};
      thr_cnt_q  <= {CNT_W{1'b0}};
    end else begin
      max_val_q  <= max_val_d;
      max_addr_q <= max_addr_d;
      obj_cnt_q  <= obj_cnt_d;
      dist_sum_q <= dist_sum_d;
      thr_cnt_q  <= thr_cnt_d;
    end
  end

  assign max_val  = max_val_q;
  assign max_addr = max_addr_q;
  assign obj_cnt  = obj_cnt_q;
  assign dist_sum = dist_sum_q;
  assign thr_cnt  = thr_cnt_q;

endmodule

// File: rtl/dt_stat.sv
`timescale 1ns/1ps
// dt_stat: raster sweep of the distance-transform result RAM producing frame statistics.
//   clk, reset        : clock, asynchronous active-low reset
//   start, thr        : begin a sweep (accepted in IDLE/DONE), threshold latched on accept
//   busy, done        : sweep in progress / results valid
//   res_rd, res_addr  : RAM read strobe and address (address forced to 0 when not reading)
//   res_di            : combinational RAM read data for res_addr
//   max_val, max_addr, obj_cnt, dist_sum, thr_cnt : frame statistics
module dt_stat
  import dt_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] thr,
  output logic              busy,
  output logic              done,
  output logic              res_rd,
  output logic [ADDR_W-1:0] res_addr,
  input  logic [DATA_W-1:0] res_di,
  output logic [DATA_W-1:0] max_val,
  output logic [ADDR_W-1:0] max_addr,
  output logic [CNT_W-1:0]  obj_cnt,
  output logic [SUM_W-1:0]  dist_sum,
  output logic [CNT_W-1:0]  thr_cnt
);

  stat_state_e       state_d, state_q;
  logic [DATA_W-1:0] thr_d, thr_q;
  logic              busy_d, busy_q;
  logic              done_d, done_q;
  logic              rd_d, rd_q;
  // The address register doubles as the raster counter; it is 0 outside SCAN.
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic              acc_clr, acc_en;

  // Next-state and registered-output logic of the sweep FSM.
  always_comb begin
    state_d = state_q;
    thr_d   = thr_q;
    busy_d  = busy_q;
    done_d  = done_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    acc_clr = 1'b0;
    acc_en  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_SCAN;
          thr_d   = thr;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          rd_d    = 1'b1;
          addr_d  = {ADDR_W{1'b0}};
          acc_clr = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_SCAN: begin
        acc_en = 1'b1;
        if (addr_q == LAST_PIX) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          rd_d    = 1'b0;
          addr_d  = {ADDR_W{1'b0}};
        end else begin
          addr_d = addr_q + ADDR_W'(1'b1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        rd_d    = 1'b0;
        addr_d  = {ADDR_W{1'b0}};
      end
    endcase
  end

  // FSM state, latched threshold and handshake registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      thr_q   <= {DATA_W{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= 1'b0;
      addr_q  <= {ADDR_W{1'b0}};
    end else begin
      state_q <= state_d;
      thr_q   <= thr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
    end
  end

  dt_stat_acc u_acc (
    .clk      (clk),
    .reset    (reset),
    .clr      (acc_clr),
    .en       (acc_en),
    .d        (res_di),
    .thr      (thr_q),
    .addr     (addr_q),
    .max_val  (max_val),
    .max_addr (max_addr),
    .obj_cnt  (obj_cnt),
    .dist_sum (dist_sum),
    .thr_cnt  (thr_cnt)
  );

  assign busy     = busy_q;
  assign done     = done_q;
  assign res_rd   = rd_q;
  assign res_addr = addr_q;

endmodule

// File: tb/tb_dt_stat.sv
`timescale 1ns/1ps
// tb_dt_stat: directed bench for dt_stat with a frame-level reference model.
module tb_dt_stat;
  import dt_pkg::*;

  localparam int NPIX = IMG_W * IMG_H;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [DATA_W-1:0] thr = 8'd0;
  logic              busy, done, res_rd;
  logic [ADDR_W-1:0] res_addr;
  logic [DATA_W-1:0] res_di;
  logic [DATA_W-1:0] max_val;
  logic [ADDR_W-1:0] max_addr;
  logic [CNT_W-1:0]  obj_cnt;
  logic [SUM_W-1:0]  dist_sum;
  logic [CNT_W-1:0]  thr_cnt;

  logic [7:0] mem [0:NPIX-1];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  assign res_di = mem[res_addr];

  dt_stat dut (
    .clk(clk), .reset(reset), .start(start), .thr(thr),
    .busy(busy), .done(done), .res_rd(res_rd), .res_addr(res_addr), .res_di(res_di),
    .max_val(max_val), .max_addr(max_addr), .obj_cnt(obj_cnt),
    .dist_sum(dist_sum), .thr_cnt(thr_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 40) $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Frame statistics straight from the image contents.
  typedef struct { int mx; int maddr; int obj; int sum; int tc; } res_t;

  function automatic res_t calc(input int t);
    res_t r;
    r.mx = 0; r.maddr = 0; r.obj = 0; r.sum = 0; r.tc = 0;
    for (int i = 0; i < NPIX; i++) begin
      if (int'(mem[i]) > r.mx) begin r.mx = int'(mem[i]); r.maddr = i; end
      if (mem[i] != 8'd0) r.obj++;
      r.sum += int'(mem[i]);
      if (int'(mem[i]) >= t) r.tc++;
    end
    return r;
  endfunction

  // Model: 0 = idle, 1 = scanning pixel m_idx, 2 = done with results e.
  int   m_mode = 0;
  int   m_idx = 0;
  res_t e;

  // Reference timeline: which pixel is being read and what the frame results must be.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode <= 0;
      m_idx  <= 0;
    end else if (m_mode == 1) begin
      if (m_idx == NPIX - 1) m_mode <= 2;
      else m_idx <= m_idx + 1;
    end else if (start) begin
      m_mode <= 1;
      m_idx  <= 0;
      e      <= calc(int'(thr));
    end
  end

  // Per-cycle comparison of the DUT against the model, away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      if (m_mode == 1) begin
        chk("scan_busy", 32'(busy), 32'd1);
        chk("scan_done", 32'(done), 32'd0);
        chk("scan_rd", 32'(res_rd), 32'd1);
        chk("scan_addr", 32'(res_addr), 32'(m_idx));
        if (m_idx == 0) begin
          chk("clr_max", 32'(max_val), 32'd0);
          chk("clr_maddr", 32'(max_addr), 32'd0);
          chk("clr_obj", 32'(obj_cnt), 32'd0);
          chk("clr_sum", 32'(dist_sum), 32'd0);
          chk("clr_thr", 32'(thr_cnt), 32'd0);
        end
      end else if (m_mode == 2) begin
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_done", 32'(done), 32'd1);
        chk("done_rd", 32'(res_rd), 32'd0);
        chk("done_addr", 32'(res_addr), 32'd0);
        chk("done_max", 32'(max_val), 32'(e.mx));
        chk("done_maddr", 32'(max_addr), 32'(e.maddr));
        chk("done_obj", 32'(obj_cnt), 32'(e.obj));
        chk("done_sum", 32'(dist_sum), 32'(e.sum));
        chk("done_thr", 32'(thr_cnt), 32'(e.tc));
      end else begin
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_rd", 32'(res_rd), 32'd0);
        chk("idle_addr", 32'(res_addr), 32'd0);
        chk("idle_max", 32'(max_val), 32'd0);
        chk("idle_obj", 32'(obj_cnt), 32'd0);
        chk("idle_sum", 32'(dist_sum), 32'd0);
      end
    end
  end

  // Called at a negedge; accepts start on the next edge and waits for done.
  task automatic run_scan(input logic [7:0] t, input bit glitch);
    int cnt;
    cnt = 0;
    start = 1'b1;
    thr   = t;
    do begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) start = 1'b0;
      if (glitch && cnt == 100) begin start = 1'b1; thr = ~t; end
      if (glitch && cnt == 101) begin start = 1'b0; thr = t; end
    end while (!done && cnt < 20000);
    chk("latency", 32'(cnt), 32'd16385);
  endtask

  task automatic expect_res(input string tag, input int mv, input int ma, input int oc,
                            input int ds, input int tc);
    chk({tag, "_max_val"}, 32'(max_val), 32'(mv));
    chk({tag, "_max_addr"}, 32'(max_addr), 32'(ma));
    chk({tag, "_obj_cnt"}, 32'(obj_cnt), 32'(oc));
    chk({tag, "_dist_sum"}, 32'(dist_sum), 32'(ds));
    chk({tag, "_thr_cnt"}, 32'(thr_cnt), 32'(tc));
  endtask

  task automatic all_zero_now(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_rd"}, 32'(res_rd), 32'd0);
    chk({tag, "_addr"}, 32'(res_addr), 32'd0);
    expect_res(tag, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NPIX; i++) mem[i] = 8'd0;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    all_zero_now("reset");
    reset = 1'b1;
    @(negedge clk);

    // All-zero image.
    run_scan(8'd1, 1'b0);
    expect_res("zero", 0, 0, 0, 0, 0);

    // Single pixel; first a sweep aborted by reset at scan cycle 8000.
    mem[5000] = 8'd3;
    start = 1'b1; thr = 8'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (7999) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    chk("pre_rst_obj", 32'(obj_cnt), 32'd1);
    #2 reset = 1'b0;
    #1 all_zero_now("midrst");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Restart with start/thr glitch during the sweep, then restart from DONE.
    run_scan(8'd3, 1'b1);
    expect_res("single", 3, 5000, 1, 3, 1);
    @(negedge clk);
    run_scan(8'd3, 1'b0);
    expect_res("single2", 3, 5000, 1, 3, 1);

    // Two tied maxima plus a smaller value at address 0.
    mem[5000] = 8'd0;
    mem[200] = 8'd7; mem[9000] = 8'd7; mem[0] = 8'd5;
    run_scan(8'd6, 1'b0);
    expect_res("ties", 7, 200, 3, 19, 2);

    // Saturated image, threshold 0.
    for (int i = 0; i < NPIX; i++) mem[i] = 8'd255;
    run_scan(8'd0, 1'b0);
    expect_res("full", 255, 0, 16384, 4177920, 16384);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
